// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the instruction and data cache controllers.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_mem0,
    input  logic              write_mem0,
    input  logic [ADDR_W-1:0] addr_mem0,
    input  logic [DATA_W-1:0] wdata_mem0,
    output logic [DATA_W-1:0] rdata_mem0,
    output logic              ready_mem0,
    input  logic              read_mem1,
    input  logic              write_mem1,
    input  logic [ADDR_W-1:0] addr_mem1,
    input  logic [DATA_W-1:0] wdata_mem1,
    output logic [DATA_W-1:0] rdata_mem1,
    output logic              ready_mem1,
    output logic              read_mem,
    output logic              write_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] wdata_mem,
    input  logic [DATA_W-1:0] rdata_mem,
    input  logic              ready_mem,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t state_r, state_s;
    logic   last_grant_r, last_grant_s;
    logic   req0_s, req1_s;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign req0_s = read_mem0 | write_mem0;
    assign req1_s = read_mem1 | write_mem1;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             timeout_err_r, timeout_hit_s;
`endif

    // Next-state and last-grant decision; last_grant records the port that just released.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
`ifdef ARB_TIMEOUT_EN
        timeout_hit_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req0_s && req1_s) begin
                    state_s = last_grant_r ? GNT0 : GNT1;
                end else if (req0_s) begin
                    state_s = GNT0;
                end else if (req1_s) begin
                    state_s = GNT1;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT0: begin
                if (!req0_s) begin
                    state_s      = TURN;
                    last_grant_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_s       = TURN;
                    last_grant_s  = 1'b0;
                    timeout_hit_s = 1'b1;
`endif
                end else begin
                    state_s = GNT0;
                end
            end
            GNT1: begin
                if (!req1_s) begin
                    state_s      = TURN;
                    last_grant_s = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_s       = TURN;
                    last_grant_s  = 1'b1;
                    timeout_hit_s = 1'b1;
`endif
                end else begin
                    state_s = GNT1;
                end
            end
            TURN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter runs only while a grant is kept; anything else restarts it.
    always_comb begin
        if ((state_r == GNT0 || state_r == GNT1) && state_s == state_r) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = '0;
        end
    end
`endif

    // State, fairness and timeout registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_r         <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
`ifdef ARB_TIMEOUT_EN
            cnt_r         <= cnt_s;
            timeout_err_r <= timeout_hit_s;
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Pass-through mux; write wins over read when an owner raises both strobes.
    always_comb begin
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        addr_mem   = '0;
        wdata_mem  = '0;
        rdata_mem0 = '0;
        rdata_mem1 = '0;
        ready_mem0 = 1'b0;
        ready_mem1 = 1'b0;
        grant      = 2'b00;
        case (state_r)
            GNT0: begin
                read_mem   = read_mem0 & ~write_mem0;
                write_mem  = write_mem0;
                addr_mem   = addr_mem0;
                wdata_mem  = wdata_mem0;
                rdata_mem0 = rdata_mem;
                ready_mem0 = ready_mem;
                grant      = 2'b01;
            end
            GNT1: begin
                read_mem   = read_mem1 & ~write_mem1;
                write_mem  = write_mem1;
                addr_mem   = addr_mem1;
                wdata_mem  = wdata_mem1;
                rdata_mem1 = rdata_mem;
                ready_mem1 = ready_mem;
                grant      = 2'b10;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

endmodule
